// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time-of-day/user-input side and the alarm stage.
// The master drives time, tick and button pulses. The slave (alarm_ctrl) drives
// the stored alarm time and the status/buzzer outputs.
interface alarm_ctrl_if;
    logic       tick;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       alarm_en;
    logic       set_mode;
    logic       hr;
    logic       min;
    logic       updown;
    logic       snooze;
    logic       stop;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       ringing;
    logic       snoozed;
    logic       buzzer;

    modport master (
        output tick, hours, minutes, seconds, alarm_en, set_mode,
               hr, min, updown, snooze, stop,
        input  alarm_hours, alarm_minutes, ringing, snoozed, buzzer
    );

    modport slave (
        input  tick, hours, minutes, seconds, alarm_en, set_mode,
               hr, min, updown, snooze, stop,
        output alarm_hours, alarm_minutes, ringing, snoozed, buzzer
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm stage: stores an adjustable alarm time, detects the match against the
// time-of-day counter and runs the ring/snooze/timeout sequence.
// Optional macro SNOOZE_LIMIT_EN caps accepted snoozes at MAX_SNOOZE per alarm.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | armed or disarmed, waiting for a match edge
// S_RINGING | buzzer beeping, ring timer counting ticks up to RING_SECS-1
// S_SNOOZE  | buzzer silent, snooze timer counting down to zero
module alarm_ctrl #(
    parameter int RST_HR      = 6,
    parameter int RST_MIN     = 0,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZE} state_t;

    localparam int RING_W     = $clog2(RING_SECS) + 1;
    localparam int SNZ_TICKS  = SNOOZE_MINS * 60;
    localparam int SNZ_W      = $clog2(SNZ_TICKS) + 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNZ_TICKS - 1);

    state_t            state_q, state_d;
    logic [4:0]        ahr_q, ahr_d;
    logic [5:0]        amin_q, amin_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic              match_q, match_d;
    logic              buzzer_q, buzzer_d;
    logic              ringing_q, ringing_d;
    logic              snoozed_q, snoozed_d;
    logic              trig;
    logic              snooze_ok;

`ifdef SNOOZE_LIMIT_EN
    localparam int NUM_W = $clog2(MAX_SNOOZE) + 1;
    logic [NUM_W-1:0] snz_num_q, snz_num_d;
    assign snooze_ok = (snz_num_q != NUM_W'(MAX_SNOOZE));
`else
    assign snooze_ok = 1'b1;
`endif

    // Alarm time adjust: hour and minute wrap independently, no carry.
    always_comb begin
        ahr_d  = ahr_q;
        amin_d = amin_q;
        if (bus.set_mode) begin
            if (bus.hr) begin
                if (bus.updown) ahr_d = (ahr_q == 5'd23) ? 5'd0 : ahr_q + 5'd1;
                else            ahr_d = (ahr_q == 5'd0) ? 5'd23 : ahr_q - 5'd1;
            end
            if (bus.min) begin
                if (bus.updown) amin_d = (amin_q == 6'd59) ? 6'd0 : amin_q + 6'd1;
                else            amin_d = (amin_q == 6'd0) ? 6'd59 : amin_q - 6'd1;
            end
        end
    end

    // Match edge detect; firing only on the rising edge prevents retrigger
    // while seconds==0 is held for several clocks.
    always_comb begin
        match_d = (bus.hours == ahr_q) && (bus.minutes == amin_q) &&
                  (bus.seconds == 6'd0);
        trig    = match_d & ~match_q & bus.alarm_en & ~bus.set_mode;
    end

    // Next-state, timers and buzzer; alarm_en low overrides everything.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        buzzer_d   = buzzer_q;
`ifdef SNOOZE_LIMIT_EN
        snz_num_d  = snz_num_q;
`endif
        if (!bus.alarm_en) begin
            state_d  = S_IDLE;
            buzzer_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    buzzer_d = 1'b0;
                    if (trig) begin
                        state_d    = S_RINGING;
                        ring_cnt_d = '0;
                        buzzer_d   = 1'b1;
`ifdef SNOOZE_LIMIT_EN
                        snz_num_d  = '0;
`endif
                    end
                end
                S_RINGING: begin
                    if (bus.stop) begin
                        state_d  = S_IDLE;
                        buzzer_d = 1'b0;
                    end else if (bus.snooze && snooze_ok) begin
                        state_d   = S_SNOOZE;
                        snz_cnt_d = SNZ_LOAD;
                        buzzer_d  = 1'b0;
`ifdef SNOOZE_LIMIT_EN
                        snz_num_d = snz_num_q + NUM_W'(1);
`endif
                    end else if (bus.tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d  = S_IDLE;
                            buzzer_d = 1'b0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RING_W'(1);
                            buzzer_d   = ~buzzer_q;
                        end
                    end
                end
                S_SNOOZE: begin
                    buzzer_d = 1'b0;
                    if (bus.stop) begin
                        state_d = S_IDLE;
                    end else if (bus.tick) begin
                        if (snz_cnt_q == '0) begin
                            state_d    = S_RINGING;
                            ring_cnt_d = '0;
                            buzzer_d   = 1'b1;
                        end else begin
                            snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    buzzer_d = 1'b0;
                end
            endcase
        end
        ringing_d = (state_d == S_RINGING);
        snoozed_d = (state_d == S_SNOOZE);
    end

    // All state, with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ahr_q      <= 5'(RST_HR);
            amin_q     <= 6'(RST_MIN);
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            match_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
`ifdef SNOOZE_LIMIT_EN
            snz_num_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ahr_q      <= ahr_d;
            amin_q     <= amin_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            match_q    <= match_d;
            buzzer_q   <= buzzer_d;
            ringing_q  <= ringing_d;
            snoozed_q  <= snoozed_d;
`ifdef SNOOZE_LIMIT_EN
            snz_num_q  <= snz_num_d;
`endif
        end
    end

    assign bus.alarm_hours   = ahr_q;
    assign bus.alarm_minutes = amin_q;
    assign bus.ringing       = ringing_q;
    assign bus.snoozed       = snoozed_q;
    assign bus.buzzer        = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: adjust wrap, match edge, ring timeout,
// snooze expiry, priorities, async reset and the snooze limit.
module tb_alarm_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    alarm_ctrl_if u_if ();

    alarm_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            u_if.tick = 1'b1;
            @(negedge clk);
            u_if.tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            u_if.hr = 1'b1;
            @(negedge clk);
            u_if.hr = 1'b0;
        end
    endtask

    task automatic pulse_min();
        u_if.min = 1'b1;
        @(negedge clk);
        u_if.min = 1'b0;
    endtask

    task automatic pulse_snooze();
        u_if.snooze = 1'b1;
        @(negedge clk);
        u_if.snooze = 1'b0;
    endtask

    task automatic pulse_stop();
        u_if.stop = 1'b1;
        @(negedge clk);
        u_if.stop = 1'b0;
    endtask

    // New rising match edge at the currently held hour/minute.
    task automatic fire();
        u_if.seconds = 6'd1;
        @(negedge clk);
        u_if.seconds = 6'd0;
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        u_if.tick     = 1'b0;
        u_if.hours    = 5'd0;
        u_if.minutes  = 6'd0;
        u_if.seconds  = 6'd0;
        u_if.alarm_en = 1'b0;
        u_if.set_mode = 1'b0;
        u_if.hr       = 1'b0;
        u_if.min      = 1'b0;
        u_if.updown   = 1'b1;
        u_if.snooze   = 1'b0;
        u_if.stop     = 1'b0;
        step(2);

        chk("rst_alarm_hours", u_if.alarm_hours, 6);
        chk("rst_alarm_minutes", u_if.alarm_minutes, 0);
        chk("rst_ringing", u_if.ringing, 0);
        chk("rst_snoozed", u_if.snoozed, 0);
        chk("rst_buzzer", u_if.buzzer, 0);
        rst = 1'b1;
        step(1);

        // Alarm adjust and wrap
        u_if.set_mode = 1'b1;
        u_if.updown   = 1'b1;
        pulse_hr(3);
        u_if.updown = 1'b0;
        pulse_min();
        chk("adj_hr_up3", u_if.alarm_hours, 9);
        chk("adj_min_wrap_down", u_if.alarm_minutes, 59);
        u_if.updown = 1'b1;
        u_if.hr     = 1'b1;
        u_if.min    = 1'b1;
        step(1);
        u_if.hr  = 1'b0;
        u_if.min = 1'b0;
        chk("adj_both_hr", u_if.alarm_hours, 10);
        chk("adj_both_min_no_carry", u_if.alarm_minutes, 0);
        pulse_hr(13);
        chk("adj_hr_23", u_if.alarm_hours, 23);
        pulse_hr(1);
        chk("adj_hr_wrap_up", u_if.alarm_hours, 0);
        u_if.updown = 1'b0;
        pulse_hr(1);
        chk("adj_hr_wrap_down", u_if.alarm_hours, 23);
        u_if.set_mode = 1'b0;
        pulse_hr(1);
        pulse_min();
        chk("adj_ignored_hr", u_if.alarm_hours, 23);
        chk("adj_ignored_min", u_if.alarm_minutes, 0);
        u_if.set_mode = 1'b1;
        pulse_hr(17);
        u_if.set_mode = 1'b0;
        u_if.updown   = 1'b1;
        chk("adj_back_to_6", u_if.alarm_hours, 6);

        // Match at 06:00:00
        u_if.hours    = 5'd5;
        u_if.minutes  = 6'd59;
        u_if.seconds  = 6'd58;
        u_if.alarm_en = 1'b1;
        step(1);
        u_if.seconds = 6'd59;
        step(1);
        chk("pre_match_ringing", u_if.ringing, 0);
        u_if.hours   = 5'd6;
        u_if.minutes = 6'd0;
        u_if.seconds = 6'd0;
        chk("match_same_cycle", u_if.ringing, 0);
        step(1);
        chk("match_ringing", u_if.ringing, 1);
        chk("match_buzzer", u_if.buzzer, 1);
        step(2);
        pulse_stop();
        chk("stop_ringing", u_if.ringing, 0);
        step(3);
        chk("no_retrigger_held", u_if.ringing, 0);

        // Buzzer pattern and ring timeout
        fire();
        chk("retrig_ringing", u_if.ringing, 1);
        ticks(1);
        chk("buzz_tick1", u_if.buzzer, 0);
        ticks(1);
        chk("buzz_tick2", u_if.buzzer, 1);
        ticks(57);
        chk("ring_tick59", u_if.ringing, 1);
        ticks(1);
        chk("ring_timeout", u_if.ringing, 0);
        chk("timeout_buzzer", u_if.buzzer, 0);

        // Snooze and expiry
        fire();
        pulse_snooze();
        chk("snz_snoozed", u_if.snoozed, 1);
        chk("snz_ringing", u_if.ringing, 0);
        chk("snz_buzzer", u_if.buzzer, 0);
        ticks(299);
        chk("snz_tick299", u_if.snoozed, 1);
        ticks(1);
        chk("snz_expire_ringing", u_if.ringing, 1);
        chk("snz_expire_snoozed", u_if.snoozed, 0);
        chk("snz_expire_buzzer", u_if.buzzer, 1);
        pulse_stop();
        chk("stop_all_ringing", u_if.ringing, 0);
        chk("stop_all_snoozed", u_if.snoozed, 0);
        chk("stop_all_buzzer", u_if.buzzer, 0);

        // stop beats snooze; alarm_en drop in SNOOZE
        fire();
        u_if.stop   = 1'b1;
        u_if.snooze = 1'b1;
        step(1);
        u_if.stop   = 1'b0;
        u_if.snooze = 1'b0;
        chk("stop_snz_ringing", u_if.ringing, 0);
        chk("stop_snz_snoozed", u_if.snoozed, 0);
        fire();
        pulse_snooze();
        chk("en_drop_pre", u_if.snoozed, 1);
        u_if.alarm_en = 1'b0;
        step(1);
        chk("en_drop_snoozed", u_if.snoozed, 0);
        chk("en_drop_ringing", u_if.ringing, 0);
        u_if.alarm_en = 1'b1;

        // Snooze limit
        fire();
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            ticks(300);
        end
        chk("limit_rering", u_if.ringing, 1);
        pulse_snooze();
`ifdef SNOOZE_LIMIT_EN
        chk("limit_4th_ringing", u_if.ringing, 1);
        chk("limit_4th_snoozed", u_if.snoozed, 0);
`else
        chk("limit_4th_ringing", u_if.ringing, 0);
        chk("limit_4th_snoozed", u_if.snoozed, 1);
`endif
        pulse_stop();
        chk("limit_stop", u_if.ringing | u_if.snoozed, 0);

        // Async reset mid-ring
        u_if.set_mode = 1'b1;
        pulse_hr(1);
        u_if.set_mode = 1'b0;
        chk("rst_pre_hr", u_if.alarm_hours, 7);
        u_if.hours = 5'd7;
        fire();
        chk("rst_pre_ringing", u_if.ringing, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_ringing", u_if.ringing, 0);
        chk("async_rst_buzzer", u_if.buzzer, 0);
        chk("async_rst_hours", u_if.alarm_hours, 6);
        chk("async_rst_minutes", u_if.alarm_minutes, 0);
        step(1);
        rst = 1'b1;
        step(2);
        chk("post_rst_ringing", u_if.ringing, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm stage directly downstream of the hours/minutes/seconds time-of-day counter; consumes its `hours`, `minutes` and `seconds` outputs plus the same 1 Hz enable that advances it.
- Holds a user-adjustable alarm time and detects the match.
- Runs a ring/snooze/timeout state machine that drives the buzzer and status outputs for the display and sound stages.

Parameters:
- RST_HR, 6, alarm hour loaded on reset (0..23).
- RST_MIN, 0, alarm minute loaded on reset (0..59).
- RING_SECS, 60, ticks spent in RINGING before automatic return to IDLE.
- SNOOZE_MINS, 5, snooze length in minutes (SNOOZE_MINS*60 ticks).
- MAX_SNOOZE, 3, snooze limit; used only when SNOOZE_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; asynchronous and active-low.
- tick  input  1  1 Hz enable, one clk cycle wide; same enable that advances the time counter.
- hours  input  5  current hour 0..23.
- minutes  input  6  current minute 0..59.
- seconds  input  6  current second 0..59.
- alarm_en  input  1  alarm armed (level).
- set_mode  input  1  alarm-adjust mode (level).
- hr  input  1  single-cycle pulse: step alarm hour.
- min  input  1  single-cycle pulse: step alarm minute.
- updown  input  1  step direction: 1 = up, 0 = down.
- snooze  input  1  single-cycle pulse, already debounced.
- stop  input  1  single-cycle pulse, already debounced.
- alarm_hours  output  5  stored alarm hour.
- alarm_minutes  output  6  stored alarm minute.
- ringing  output  1  high in RINGING.
- snoozed  output  1  high in SNOOZE.
- buzzer  output  1  beep pattern output.

Behaviour:
- Reset (rst low, asynchronous), all registers take these values:
  - alarm_hours = RST_HR, alarm_minutes = RST_MIN.
  - State IDLE; ringing = snoozed = buzzer = 0.
  - Ring and snooze counters 0; match_d = 0; snooze count 0.
- Alarm adjust, only when set_mode = 1:
  - hr pulse steps alarm_hours by ±1 with wrap: 23→0 up, 0→23 down.
  - min pulse steps alarm_minutes by ±1 with wrap: 59→0 up, 0→59 down. The hour is not affected (no carry).
  - hr and min in the same cycle: both step.
  - set_mode = 0: hr and min are ignored.
  - Adjusting never changes the FSM state.
- Match detection:
  - match = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 0).
  - match_d is match registered every cycle.
  - trig = match & ~match_d & alarm_en & ~set_mode. This is a rising edge, so an alarm fires at most once per occurrence. Match at reset release fires one cycle later, because match_d resets to 0.
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE → RINGING on trig. Ring counter cleared, buzzer set to 1, snooze count cleared.
  - RINGING:
    - Each tick increments the ring counter and toggles buzzer.
    - When the ring counter reaches RING_SECS-1 and tick is high → IDLE (auto-timeout).
    - stop → IDLE.
    - snooze → SNOOZE. The snooze counter loads SNOOZE_MINS*60-1.
  - SNOOZE:
    - Each tick decrements the snooze counter.
    - tick with counter == 0 → RINGING. Ring counter cleared, buzzer = 1.
    - stop → IDLE.
    - trig is ignored.
- Priority, highest first, in any state: alarm_en = 0 (forces IDLE next cycle) > stop > snooze > timeout/expiry > tick counting.
- Outputs:
  - ringing and snoozed are registered state decodes.
  - buzzer is 0 outside RINGING.
  - Latency from event to output change is one clk.
- Counter widths: $clog2 of the respective maximum count + 1. Wrap beyond the terminal count is not allowed.
- A time counter that jumps (manual adjust or midnight wrap) only affects detection through the match edge. No other side effects.

Optional Feature:
- Macro: SNOOZE_LIMIT_EN.
- Defined:
  - A snooze counter (cleared on IDLE → RINGING) increments on each accepted snooze.
  - Once it equals MAX_SNOOZE, further snooze pulses in RINGING are ignored; only stop or timeout exit.
  - Expiry of the last snooze still re-enters RINGING.
- Not defined: snooze is unlimited and MAX_SNOOZE is unused.

Test Plan:
- Reset release, then set_mode = 1, updown = 1, 3 hr pulses, then updown = 0, 1 min pulse → alarm_hours = 9, alarm_minutes = 59. From 23 with up → 0; from 0 with down → 23.
- Alarm 06:00, alarm_en = 1, time runs 05:59:58 → 06:00:00 → ringing = 1 one clk after seconds = 0. buzzer toggles 1,0,1 on successive ticks. ringing drops after 60 ticks. No retrigger while seconds = 0 is held across several clk.
- While RINGING, snooze pulse → snoozed = 1. After 300 ticks, ringing = 1 again. Then stop → IDLE, all outputs 0.
- stop and snooze in the same cycle during RINGING → IDLE. alarm_en dropped during SNOOZE → IDLE next clk.
- rst asserted mid-RINGING → ringing = buzzer = 0 immediately, without waiting for clk. Alarm time returns to 06:00.
- SNOOZE_LIMIT_EN defined with MAX_SNOOZE = 3 → the 4th snooze pulse is ignored and ringing stays 1. With the macro undefined, the 4th snooze enters SNOOZE.
